// File: rtl/hardwired_sequencer.sv
// Hardwired control sequencer for the accumulator CPU: T-state counter, instruction decode and strobe generation.
// Optional interrupt cycle with IEN/R flags is enabled by defining CU_INTERRUPT_EN.
module hardwired_sequencer #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 12,
   parameter int SC_W   = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] ir,
   input  logic              ac_zero,
   input  logic              ac_neg,
   input  logic              dr_zero,
   input  logic              mem_ready,
   input  logic              start,
   input  logic              irq,
   output logic [5:0]        ld,
   output logic [3:0]        inr,
   output logic [3:0]        clr,
   output logic              rd,
   output logic              wr,
   output logic [7:0]        bus_sel,
   output logic [2:0]        alu_op,
   output logic              halted,
   output logic [SC_W-1:0]   sc
);

   localparam logic [SC_W-1:0] T0 = SC_W'(0);
   localparam logic [SC_W-1:0] T1 = SC_W'(1);
   localparam logic [SC_W-1:0] T2 = SC_W'(2);
   localparam logic [SC_W-1:0] T3 = SC_W'(3);
   localparam logic [SC_W-1:0] T4 = SC_W'(4);
   localparam logic [SC_W-1:0] T5 = SC_W'(5);
   localparam logic [SC_W-1:0] T6 = SC_W'(6);

   localparam int LD_TR = 5, LD_AR = 4, LD_PC = 3, LD_DR = 2, LD_AC = 1, LD_IR = 0;
   localparam int R_AR = 3, R_PC = 2, R_DR = 1, R_AC = 0;

   localparam logic [7:0] BUS_AR  = 8'h02;
   localparam logic [7:0] BUS_PC  = 8'h04;
   localparam logic [7:0] BUS_DR  = 8'h08;
   localparam logic [7:0] BUS_AC  = 8'h10;
   localparam logic [7:0] BUS_IR  = 8'h20;
   localparam logic [7:0] BUS_TR  = 8'h40;
   localparam logic [7:0] BUS_MEM = 8'h80;

   logic [SC_W-1:0]   sc_q;
   logic              halted_q;
   logic              i_bit;
   logic [2:0]        opcode;
   logic [ADDR_W-1:0] addr_field;
   logic              int_cycle;
   logic              mem_op;
   logic              step;
   logic              finish;
   logic              set_halt;
   logic              intr_done;
   logic              unused_bits;

   assign i_bit       = ir[DATA_W-1];
   assign opcode      = ir[DATA_W-2 -: 3];
   assign addr_field  = ir[ADDR_W-1:0];
   assign unused_bits = ^{ir, addr_field, irq};

`ifdef CU_INTERRUPT_EN
   logic ien_q;
   logic r_q;
   logic ion;
   logic iof;
   assign int_cycle = r_q && (sc_q <= T2);
`else
   assign int_cycle = 1'b0;
`endif

   // Decode the current T-state into strobes; memory states stall until mem_ready.
   always_comb begin
      ld        = '0;
      inr       = '0;
      clr       = '0;
      rd        = 1'b0;
      wr        = 1'b0;
      bus_sel   = '0;
      alu_op    = '0;
      mem_op    = 1'b0;
      finish    = 1'b0;
      set_halt  = 1'b0;
      intr_done = 1'b0;
`ifdef CU_INTERRUPT_EN
      ion       = 1'b0;
      iof       = 1'b0;
`endif
      if (reset) begin
         clr[R_PC] = 1'b1;
      end else if (!halted_q) begin
         if (int_cycle) begin
            case (sc_q)
               T0: begin clr[R_AR] = 1'b1; bus_sel = BUS_PC; ld[LD_TR] = 1'b1; end
               T1: begin wr = 1'b1; mem_op = 1'b1; bus_sel = BUS_TR; clr[R_PC] = 1'b1; end
               default: begin inr[R_PC] = 1'b1; intr_done = 1'b1; finish = 1'b1; end
            endcase
         end else begin
            case (sc_q)
               T0: begin bus_sel = BUS_PC; ld[LD_AR] = 1'b1; end
               T1: begin
                  rd = 1'b1; mem_op = 1'b1; bus_sel = BUS_MEM;
                  ld[LD_IR] = 1'b1; inr[R_PC] = 1'b1;
               end
               T2: begin bus_sel = BUS_IR; ld[LD_AR] = 1'b1; end
               T3: begin
                  if (opcode == 3'd7) begin
                     finish = 1'b1;
                     if (!i_bit) begin
                        clr[R_AC] = addr_field[11];
                        if (addr_field[9])      alu_op = 3'd4;
                        else if (addr_field[7]) alu_op = 3'd5;
                        else if (addr_field[6]) alu_op = 3'd6;
                        ld[LD_AC]  = addr_field[9] | addr_field[7] | addr_field[6];
                        inr[R_AC]  = addr_field[5];
                        inr[R_PC]  = (addr_field[4] & ~ac_neg & ~ac_zero)
                                   | (addr_field[3] & ac_neg)
                                   | (addr_field[2] & ac_zero);
                        set_halt   = addr_field[0];
                     end else begin
`ifdef CU_INTERRUPT_EN
                        ion = addr_field[7];
                        iof = addr_field[6];
`endif
                     end
                  end else if (i_bit) begin
                     rd = 1'b1; mem_op = 1'b1; bus_sel = BUS_MEM; ld[LD_AR] = 1'b1;
                  end
               end
               T4: begin
                  case (opcode)
                     3'd0, 3'd1, 3'd2, 3'd6: begin
                        rd = 1'b1; mem_op = 1'b1; bus_sel = BUS_MEM; ld[LD_DR] = 1'b1;
                     end
                     3'd3: begin wr = 1'b1; mem_op = 1'b1; bus_sel = BUS_AC; finish = 1'b1; end
                     3'd4: begin bus_sel = BUS_AR; ld[LD_PC] = 1'b1; finish = 1'b1; end
                     3'd5: begin
                        wr = 1'b1; mem_op = 1'b1; bus_sel = BUS_PC; inr[R_AR] = 1'b1;
                     end
                     default: ;
                  endcase
               end
               T5: begin
                  case (opcode)
                     3'd0, 3'd1, 3'd2: begin
                        ld[LD_AC] = 1'b1; alu_op = opcode + 3'd1; finish = 1'b1;
                     end
                     3'd5: begin bus_sel = BUS_AR; ld[LD_PC] = 1'b1; finish = 1'b1; end
                     3'd6: inr[R_DR] = 1'b1;
                     default: ;
                  endcase
               end
               T6: begin
                  if (opcode == 3'd6) begin
                     wr = 1'b1; mem_op = 1'b1; bus_sel = BUS_DR;
                     inr[R_PC] = dr_zero; finish = 1'b1;
                  end
               end
               default: ;
            endcase
         end
         if (mem_op && !mem_ready) begin
            ld  = '0;
            inr = '0;
            clr = '0;
         end
      end
   end

   assign step   = !mem_op || mem_ready;
   assign halted = halted_q & ~reset;
   assign sc     = reset ? '0 : sc_q;

   // Sequence counter and halt flag; a halted machine parks at T0 until start.
   always_ff @(posedge clk) begin
      if (reset) begin
         sc_q     <= '0;
         halted_q <= 1'b0;
      end else if (halted_q) begin
         sc_q <= '0;
         if (start) halted_q <= 1'b0;
      end else if (step) begin
         sc_q <= finish ? '0 : sc_q + SC_W'(1);
         if (set_halt) halted_q <= 1'b1;
      end
   end

`ifdef CU_INTERRUPT_EN
   // R latches a request only outside fetch so the interrupt cycle always starts at a clean T0.
   always_ff @(posedge clk) begin
      if (reset) begin
         ien_q <= 1'b0;
         r_q   <= 1'b0;
      end else begin
         if (ion) ien_q <= 1'b1;
         if (iof) ien_q <= 1'b0;
         if (intr_done) begin
            ien_q <= 1'b0;
            r_q   <= 1'b0;
         end else if (!halted_q && (sc_q > T2) && ien_q && irq && !r_q) begin
            r_q <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_hardwired_sequencer.sv
// Scoreboard bench for hardwired_sequencer: stimulus queues hand-computed per-cycle output vectors,
// a negedge monitor pops and compares them against the packed DUT outputs.
module tb_hardwired_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] ir;
   logic        ac_zero, ac_neg, dr_zero, mem_ready, start, irq;
   logic [5:0]  ld;
   logic [3:0]  inr, clr;
   logic        rd, wr;
   logic [7:0]  bus_sel;
   logic [2:0]  alu_op;
   logic        halted;
   logic [3:0]  sc;

   int errors = 0;
   int checks = 0;

   string       nameQ[$];
   logic [31:0] expQ[$];

   hardwired_sequencer #(.DATA_W(16), .ADDR_W(12), .SC_W(4)) dut (
      .clk(clk), .reset(reset), .ir(ir), .ac_zero(ac_zero), .ac_neg(ac_neg),
      .dr_zero(dr_zero), .mem_ready(mem_ready), .start(start), .irq(irq),
      .ld(ld), .inr(inr), .clr(clr), .rd(rd), .wr(wr), .bus_sel(bus_sel),
      .alu_op(alu_op), .halted(halted), .sc(sc)
   );

   always #5 clk = ~clk;

   // Packs one cycle's outputs as {ld, inr, clr, rd, wr, bus_sel, alu_op, halted, sc}.
   function automatic logic [31:0] ov(input logic [5:0] l, input logic [3:0] i, input logic [3:0] c,
                                      input logic r, input logic w, input logic [7:0] b,
                                      input logic [2:0] a, input logic h, input logic [3:0] s);
      return {l, i, c, r, w, b, a, h, s};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] exp);
      logic [31:0] got;
      got = {ld, inr, clr, rd, wr, bus_sel, alu_op, halted, sc};
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (expQ.size() > 0) checkOutput(nameQ.pop_front(), expQ.pop_front());
   end

   task automatic applyStimulus(input string name, input logic [31:0] exp);
      nameQ.push_back(name);
      expQ.push_back(exp);
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input string tag);
      applyStimulus({tag, "_t0"}, ov(6'b010000, 4'b0000, 4'b0000, 0, 0, 8'h04, 3'd0, 0, 4'd0));
      applyStimulus({tag, "_t1"}, ov(6'b000001, 4'b0100, 4'b0000, 1, 0, 8'h80, 3'd0, 0, 4'd1));
      applyStimulus({tag, "_t2"}, ov(6'b010000, 4'b0000, 4'b0000, 0, 0, 8'h20, 3'd0, 0, 4'd2));
   endtask

   task automatic idleT3(input string tag);
      applyStimulus({tag, "_t3"}, ov(6'b0, 4'b0, 4'b0, 0, 0, 8'h00, 3'd0, 0, 4'd3));
   endtask

   task automatic memLoadDR(input string tag);
      applyStimulus({tag, "_t4"}, ov(6'b000100, 4'b0, 4'b0, 1, 0, 8'h80, 3'd0, 0, 4'd4));
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [31:0] rst_v, halt_v;
      rst_v  = ov(6'b0, 4'b0, 4'b0100, 0, 0, 8'h00, 3'd0, 0, 4'd0);
      halt_v = ov(6'b0, 4'b0, 4'b0, 0, 0, 8'h00, 3'd0, 1, 4'd0);
      reset = 1; ir = 16'h0000; ac_zero = 0; ac_neg = 0; dr_zero = 0;
      mem_ready = 1; start = 0; irq = 0;
      @(posedge clk);
      #1;
      applyStimulus("reset_a", rst_v);
      applyStimulus("reset_b", rst_v);
      reset = 0;

      ir = 16'h2005;
      fetch("lda");
      idleT3("lda");
      memLoadDR("lda");
      applyStimulus("lda_t5", ov(6'b000010, 4'b0, 4'b0, 0, 0, 8'h00, 3'd3, 0, 4'd5));

      ir = 16'hA005;
      fetch("ldai");
      applyStimulus("ldai_t3", ov(6'b010000, 4'b0, 4'b0, 1, 0, 8'h80, 3'd0, 0, 4'd3));
      memLoadDR("ldai");
      applyStimulus("ldai_t5", ov(6'b000010, 4'b0, 4'b0, 0, 0, 8'h00, 3'd3, 0, 4'd5));

      ir = 16'h6005;
      fetch("isz");
      idleT3("isz");
      mem_ready = 0;
      for (int k = 0; k < 3; k++)
         applyStimulus("isz_t4_wait", ov(6'b0, 4'b0, 4'b0, 1, 0, 8'h80, 3'd0, 0, 4'd4));
      mem_ready = 1;
      memLoadDR("isz");
      applyStimulus("isz_t5", ov(6'b0, 4'b0010, 4'b0, 0, 0, 8'h00, 3'd0, 0, 4'd5));
      dr_zero = 1;
      applyStimulus("isz_t6", ov(6'b0, 4'b0100, 4'b0, 0, 1, 8'h08, 3'd0, 0, 4'd6));
      dr_zero = 0;

      ir = 16'h3005;
      fetch("sta");
      idleT3("sta");
      applyStimulus("sta_t4", ov(6'b0, 4'b0, 4'b0, 0, 1, 8'h10, 3'd0, 0, 4'd4));

      ir = 16'h4005;
      fetch("bun");
      idleT3("bun");
      applyStimulus("bun_t4", ov(6'b001000, 4'b0, 4'b0, 0, 0, 8'h02, 3'd0, 0, 4'd4));

      ir = 16'h5005;
      fetch("bsa");
      idleT3("bsa");
      mem_ready = 0;
      applyStimulus("bsa_t4_wait", ov(6'b0, 4'b0, 4'b0, 0, 1, 8'h04, 3'd0, 0, 4'd4));
      mem_ready = 1;
      applyStimulus("bsa_t4", ov(6'b0, 4'b1000, 4'b0, 0, 1, 8'h04, 3'd0, 0, 4'd4));
      applyStimulus("bsa_t5", ov(6'b001000, 4'b0, 4'b0, 0, 0, 8'h02, 3'd0, 0, 4'd5));

      ir = 16'h7004; ac_zero = 1;
      fetch("sza");
      applyStimulus("sza_t3", ov(6'b0, 4'b0100, 4'b0, 0, 0, 8'h00, 3'd0, 0, 4'd3));
      ac_zero = 0;

      ir = 16'h7010; ac_neg = 1;
      fetch("spa");
      idleT3("spa_noskip");
      ir = 16'h7008;
      fetch("sna");
      applyStimulus("sna_t3", ov(6'b0, 4'b0100, 4'b0, 0, 0, 8'h00, 3'd0, 0, 4'd3));
      ac_neg = 0;

      ir = 16'h7A60;
      fetch("cla_cma");
      applyStimulus("cla_cma_t3", ov(6'b000010, 4'b0001, 4'b0001, 0, 0, 8'h00, 3'd4, 0, 4'd3));

      ir = 16'h70C0; start = 1;
      fetch("cir");
      start = 0;
      applyStimulus("cir_t3", ov(6'b000010, 4'b0, 4'b0, 0, 0, 8'h00, 3'd5, 0, 4'd3));

      ir = 16'h7001;
      fetch("hlt");
      idleT3("hlt");
      for (int k = 0; k < 10; k++) applyStimulus("halted_idle", halt_v);
      start = 1;
      applyStimulus("halted_start", halt_v);
      start = 0;
      ir = 16'h2005;
      fetch("resume");
      idleT3("resume");
      memLoadDR("resume");
      applyStimulus("resume_t5", ov(6'b000010, 4'b0, 4'b0, 0, 0, 8'h00, 3'd3, 0, 4'd5));

      ir = 16'h6005;
      fetch("iszrst");
      idleT3("iszrst");
      memLoadDR("iszrst");
      reset = 1;
      applyStimulus("iszrst_t5", rst_v);
      applyStimulus("iszrst_hold", rst_v);
      reset = 0;
      ir = 16'h4005;
      fetch("after_rst");
      idleT3("after_rst");
      applyStimulus("after_rst_t4", ov(6'b001000, 4'b0, 4'b0, 0, 0, 8'h02, 3'd0, 0, 4'd4));

`ifdef CU_INTERRUPT_EN
      ir = 16'hF080;
      fetch("ion");
      idleT3("ion");
      ir = 16'h1005;
      fetch("add");
      idleT3("add");
      irq = 1;
      memLoadDR("add");
      irq = 0;
      applyStimulus("add_t5", ov(6'b000010, 4'b0, 4'b0, 0, 0, 8'h00, 3'd2, 0, 4'd5));
      applyStimulus("rt0", ov(6'b100000, 4'b0, 4'b1000, 0, 0, 8'h04, 3'd0, 0, 4'd0));
      mem_ready = 0;
      applyStimulus("rt1_wait", ov(6'b0, 4'b0, 4'b0, 0, 1, 8'h40, 3'd0, 0, 4'd1));
      mem_ready = 1;
      applyStimulus("rt1", ov(6'b0, 4'b0, 4'b0100, 0, 1, 8'h40, 3'd0, 0, 4'd1));
      applyStimulus("rt2", ov(6'b0, 4'b0100, 4'b0, 0, 0, 8'h00, 3'd0, 0, 4'd2));
      ir = 16'h2005; irq = 1;
      fetch("ien_off");
      idleT3("ien_off");
      memLoadDR("ien_off");
      applyStimulus("ien_off_t5", ov(6'b000010, 4'b0, 4'b0, 0, 0, 8'h00, 3'd3, 0, 4'd5));
      ir = 16'h7000;
      fetch("no_rt");
      idleT3("no_rt");
      irq = 0;
`else
      ir = 16'hF080; irq = 1;
      fetch("io_nop");
      idleT3("io_nop");
      ir = 16'h7000;
      fetch("no_rt");
      idleT3("no_rt");
      irq = 0;
`endif

      @(posedge clk);
      #1;
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", expQ.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
